// File: rtl/imgram_fill_arbiter_pkg.sv
// Shared definitions for the imgram port-A arbiter and its rectangle-fill engine.
// Holds the fill FSM state encoding and the default screen geometry.
package imgram_fill_arbiter_pkg;

    localparam int IMG_ADDR_W    = 19;
    localparam int PIX_W         = 8;
    localparam int FILL_DIM_W    = 10;
    localparam int SCREEN_STRIDE = 640;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/imgram_fill_arbiter_if.sv
// imgram port bundle: the processor-side access (req/addr/data/wren/q) and the
// port-A memory side (addr/data/wren/q).
// Modports:
//   master - the arbiter: consumes processor requests and mem_q, drives proc_q and mem_*
//   slave  - the environment: drives processor requests and mem_q, observes the rest
interface imgram_fill_arbiter_if
    import imgram_fill_arbiter_pkg::*;
#(
    parameter int ADDR_W = IMG_ADDR_W,
    parameter int DATA_W = PIX_W
) ();

    logic              proc_req;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_data;
    logic              proc_wren;
    logic [DATA_W-1:0] proc_q;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport master (
        input  proc_req, proc_addr, proc_data, proc_wren, mem_q,
        output proc_q, mem_addr, mem_data, mem_wren
    );

    modport slave (
        output proc_req, proc_addr, proc_data, proc_wren, mem_q,
        input  proc_q, mem_addr, mem_data, mem_wren
    );

endinterface

// File: rtl/imgram_fill_arbiter_fill_addr_gen.sv
// Rectangle walker for the fill engine: column/row counters, row-base accumulator,
// last-pixel flag and the advance enable (engine running and port free).
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   load              - accepted start: latch base/w/h and rewind to pixel (0,0)
//   base, w, h        - rectangle origin address and dimensions
//   run, stall, abort - engine in fill state / processor owns the port / abort request
//   adv               - a pixel is written this cycle
//   addr              - address of the current pixel (row_base + col, modulo 2^ADDR_W)
//   last              - current pixel is the bottom-right one
module fill_addr_gen
    import imgram_fill_arbiter_pkg::*;
#(
    parameter int ADDR_W = IMG_ADDR_W,
    parameter int DIM_W  = FILL_DIM_W,
    parameter int STRIDE = SCREEN_STRIDE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [DIM_W-1:0]  w,
    input  logic [DIM_W-1:0]  h,
    input  logic              run,
    input  logic              stall,
    input  logic              abort,
    output logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [DIM_W-1:0]  col_r;
    logic [DIM_W-1:0]  row_r;
    logic [DIM_W-1:0]  w_r;
    logic [DIM_W-1:0]  h_r;
    logic [ADDR_W-1:0] row_base_r;
    logic              col_end_s;

    // Abort suppresses the write in its own cycle, so it also blocks the advance.
    assign adv       = run & ~stall & ~abort;
    assign col_end_s = (col_r == (w_r - DIM_W'(1)));
    assign last      = col_end_s & (row_r == (h_r - DIM_W'(1)));
    assign addr      = row_base_r + ADDR_W'(col_r);

    // Counter/accumulator state: rewound on load, stepped on each written pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_r      <= '0;
            row_r      <= '0;
            w_r        <= '0;
            h_r        <= '0;
            row_base_r <= '0;
        end else if (load) begin
            col_r      <= '0;
            row_r      <= '0;
            w_r        <= w;
            h_r        <= h;
            row_base_r <= base;
        end else if (adv) begin
            if (col_end_s) begin
                col_r      <= '0;
                row_r      <= row_r + DIM_W'(1);
                row_base_r <= row_base_r + ADDR_W'(STRIDE);
            end else begin
                col_r      <= col_r + DIM_W'(1);
            end
        end else begin
            col_r      <= col_r;
            row_r      <= row_r;
            row_base_r <= row_base_r;
        end
    end

endmodule

// File: rtl/imgram_fill_arbiter.sv
// Owns imgram port A and shares it between the processor and a rectangle-fill engine.
// The processor always wins the port; the engine writes only in cycles with proc_req=0.
// Ports:
//   clock, reset                  - clock and synchronous active-high reset
//   bus (master)                  - processor access in, port-A memory signals out
//   fill_start, fill_abort        - start pulse (accepted only when idle) / stop active fill
//   fill_base, fill_w, fill_h     - rectangle origin and size, sampled on accepted start
//   fill_color                    - pixel value written, sampled on accepted start
//   fill_busy, fill_done          - engine active / one-cycle completion pulse
//   fill_grant                    - engine writes the port this cycle
module imgram_fill_arbiter
    import imgram_fill_arbiter_pkg::*;
#(
    parameter int ADDR_W = IMG_ADDR_W,
    parameter int DATA_W = PIX_W,
    parameter int DIM_W  = FILL_DIM_W,
    parameter int STRIDE = SCREEN_STRIDE
) (
    input  logic                 clock,
    input  logic                 reset,
    imgram_fill_arbiter_if.master bus,
    input  logic                 fill_start,
    input  logic                 fill_abort,
    input  logic [ADDR_W-1:0]    fill_base,
    input  logic [DIM_W-1:0]     fill_w,
    input  logic [DIM_W-1:0]     fill_h,
    input  logic [DATA_W-1:0]    fill_color,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 fill_grant
);

    fill_state_e       state_r;
    fill_state_e       state_s;
    logic [DATA_W-1:0] color_r;
    logic              busy_r;
    logic              done_r;
    logic              load_s;
    logic              adv_s;
    logic              last_s;
    logic [ADDR_W-1:0] pix_addr_s;

    assign load_s    = (state_r == FILL_IDLE) & fill_start;
    assign fill_busy = busy_r;
    assign fill_done = done_r;
    assign bus.proc_q = bus.mem_q;

    fill_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W),
        .STRIDE (STRIDE)
    ) u_addr_gen (
        .clock (clock),
        .reset (reset),
        .load  (load_s),
        .base  (fill_base),
        .w     (fill_w),
        .h     (fill_h),
        .run   (state_r == FILL_RUN),
        .stall (bus.proc_req),
        .abort (fill_abort),
        .adv   (adv_s),
        .addr  (pix_addr_s),
        .last  (last_s)
    );

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= FILL_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            color_r <= '0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != FILL_IDLE);
            done_r  <= (state_s == FILL_DONE);
            if (load_s) begin
                color_r <= fill_color;
            end else begin
                color_r <= color_r;
            end
        end
    end

    // Next-state logic; abort only matters while filling.
    always_comb begin
        state_s = state_r;
        case (state_r)
            FILL_IDLE: begin
                if (fill_start) begin
                    if ((fill_w == '0) || (fill_h == '0)) begin
                        state_s = FILL_DONE;
                    end else begin
                        state_s = FILL_RUN;
                    end
                end else begin
                    state_s = FILL_IDLE;
                end
            end
            FILL_RUN: begin
                if (fill_abort) begin
                    state_s = FILL_IDLE;
                end else if (adv_s && last_s) begin
                    state_s = FILL_DONE;
                end else begin
                    state_s = FILL_RUN;
                end
            end
            FILL_DONE: state_s = FILL_IDLE;
            default:   state_s = FILL_IDLE;
        endcase
    end

    // Port-A mux: memory is clocked on the opposite edge, so this path stays combinational.
    always_comb begin
        bus.mem_addr = bus.proc_addr;
        bus.mem_data = bus.proc_data;
        bus.mem_wren = bus.proc_wren & bus.proc_req;
        fill_grant   = 1'b0;
        if (adv_s) begin
            bus.mem_addr = pix_addr_s;
            bus.mem_data = color_r;
            bus.mem_wren = 1'b1;
            fill_grant   = 1'b1;
        end else begin
            fill_grant   = 1'b0;
        end
    end

endmodule

// File: tb/tb_imgram_fill_arbiter.sv
// Self-checking bench for imgram_fill_arbiter: table of directed fills, hand-written
// stall/abort/reset sequences and randomized fills against a pixel-list model.
module tb_imgram_fill_arbiter;

    logic        clock;
    logic        reset;
    logic        fill_start;
    logic        fill_abort;
    logic [18:0] fill_base;
    logic [9:0]  fill_w;
    logic [9:0]  fill_h;
    logic [7:0]  fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic        fill_grant;

    int n_tests = 0;
    int n_fail  = 0;

    imgram_fill_arbiter_if bus ();

    imgram_fill_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .fill_start (fill_start),
        .fill_abort (fill_abort),
        .fill_base  (fill_base),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fill_grant (fill_grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_proc(input bit req);
        bus.proc_req  = req;
        bus.proc_addr = 19'($urandom);
        bus.proc_data = 8'($urandom);
        bus.proc_wren = 1'($urandom_range(1));
        bus.mem_q     = 8'($urandom);
    endtask

    // Processor pass-through checks for a cycle where the processor owns the port.
    task automatic chk_proc_path();
        chk("proc_addr_pass", 32'(bus.mem_addr), 32'(bus.proc_addr));
        chk("proc_data_pass", 32'(bus.mem_data), 32'(bus.proc_data));
        chk("proc_wren_pass", 32'(bus.mem_wren), 32'(bus.proc_wren));
        chk("proc_q_pass",    32'(bus.proc_q),   32'(bus.mem_q));
    endtask

    // Run one fill. The model holds the count of pixels still owed; pixel k of the
    // rectangle lives at base + (k / w) * 640 + (k % w), modulo 2^19.
    // Processor requests cycles [lo,hi) relative to start plus pct% random cycles.
    // abort_at >= 0 raises fill_abort once that many pixels have been written.
    task automatic run_fill(input logic [18:0] base, input int w, input int h,
                            input logic [7:0] color, input int lo, input int hi,
                            input int pct, input int abort_at,
                            output int nwr, output int done_cyc, output logic [18:0] last_addr);
        int rem;
        int k;
        int c;
        bit req;
        bit ab;
        bit fin;
        logic [18:0] ea;
        nwr = 0; done_cyc = -1; last_addr = 19'd0; fin = 1'b0;
        fill_base = base; fill_w = 10'(w); fill_h = 10'(h); fill_color = color;
        fill_start = 1'b1; fill_abort = 1'b0;
        drive_proc(1'b0);
        #1;
        chk("idle_grant", 32'(fill_grant), 32'd0);
        chk("idle_busy", 32'(fill_busy), 32'd0);
        step();
        fill_start = 1'b0;
        rem = w * h;
        c = 1;
        while (!fin && c < 3000) begin
            req = ((c >= lo) && (c < hi)) || (32'($urandom_range(99)) < 32'(pct));
            ab  = (abort_at >= 0) && (nwr == abort_at) && (rem > 0);
            drive_proc(req);
            fill_abort = ab;
            // Stray start with different config must be ignored while busy.
            fill_start = (rem > 0) && ($urandom_range(7) == 0);
            fill_color = ~color;
            fill_base  = 19'($urandom);
            fill_w     = 10'($urandom_range(9));
            fill_h     = 10'($urandom_range(9));
            #1;
            chk("busy", 32'(fill_busy), 32'd1);
            chk("done", 32'(fill_done), (rem == 0) ? 32'd1 : 32'd0);
            chk("grant", 32'(fill_grant), (rem > 0 && !req && !ab) ? 32'd1 : 32'd0);
            if (req) chk_proc_path();
            else if (!fill_grant) chk("idle_wren", 32'(bus.mem_wren), 32'd0);
            if (fill_grant && bus.mem_wren) begin
                nwr++;
                last_addr = bus.mem_addr;
            end
            if (rem > 0 && !req && !ab) begin
                k  = w * h - rem;
                ea = base + 19'((k / w) * 640 + (k % w));
                chk("pix_addr", 32'(bus.mem_addr), 32'(ea));
                chk("pix_data", 32'(bus.mem_data), 32'(color));
                chk("pix_wren", 32'(bus.mem_wren), 32'd1);
                rem--;
            end else if (rem == 0) begin
                done_cyc = c;
                fin = 1'b1;
            end
            step();
            fill_start = 1'b0;
            if (ab) begin
                fill_abort = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    drive_proc(1'b0);
                    #1;
                    chk("abort_busy", 32'(fill_busy), 32'd0);
                    chk("abort_done", 32'(fill_done), 32'd0);
                    chk("abort_grant", 32'(fill_grant), 32'd0);
                    step();
                end
                fin = 1'b1;
            end
            c++;
        end
        if (!fin) chk("fill_timeout", 32'(c), 32'd0);
        if (!ab) begin
            drive_proc(1'b0);
            #1;
            chk("post_busy", 32'(fill_busy), 32'd0);
            chk("post_done", 32'(fill_done), 32'd0);
            step();
        end
    endtask

    typedef struct {
        logic [18:0] base;
        int          w;
        int          h;
        logic [7:0]  color;
        int          lo;
        int          hi;
        int          exp_nwr;
        int          exp_done;
        logic [18:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int nwr;
        int dcyc;
        int w;
        int h;
        int ab;
        logic [18:0] la;
        logic [18:0] base;

        vecs[0] = '{19'd0,      4, 2, 8'h3C, 0, 0, 8, 9,  19'd643};
        vecs[1] = '{19'd0,      4, 2, 8'h3C, 2, 5, 8, 12, 19'd643};
        vecs[2] = '{19'd0,      0, 5, 8'h11, 0, 0, 0, 1,  19'd0};
        vecs[3] = '{19'd5,      3, 0, 8'h22, 0, 0, 0, 1,  19'd0};
        vecs[4] = '{19'h7FFFE,  4, 1, 8'hA5, 0, 0, 4, 5,  19'd1};
        vecs[5] = '{19'd100,    3, 3, 8'h5A, 0, 0, 9, 10, 19'd1382};
        vecs[6] = '{19'h7FF00,  2, 2, 8'hFF, 0, 0, 4, 5,  19'd385};

        reset = 1'b1; fill_start = 1'b0; fill_abort = 1'b0;
        fill_base = 19'd0; fill_w = 10'd0; fill_h = 10'd0; fill_color = 8'd0;
        drive_proc(1'b0);
        step();
        step();
        chk("rst_busy", 32'(fill_busy), 32'd0);
        chk("rst_done", 32'(fill_done), 32'd0);
        chk("rst_grant", 32'(fill_grant), 32'd0);
        chk("rst_wren_noreq", 32'(bus.mem_wren), 32'd0);
        bus.proc_req = 1'b1; bus.proc_wren = 1'b1;
        #1;
        chk("rst_wren_req", 32'(bus.mem_wren), 32'd1);
        chk_proc_path();
        reset = 1'b0;
        step();

        // Directed table.
        foreach (vecs[i]) begin
            run_fill(vecs[i].base, vecs[i].w, vecs[i].h, vecs[i].color,
                     vecs[i].lo, vecs[i].hi, 0, -1, nwr, dcyc, la);
            chk($sformatf("vec%0d_nwr", i), 32'(nwr), 32'(vecs[i].exp_nwr));
            chk($sformatf("vec%0d_done_cyc", i), 32'(dcyc), 32'(vecs[i].exp_done));
            chk($sformatf("vec%0d_last_addr", i), 32'(la), 32'(vecs[i].exp_last));
        end

        // Abort after 5 writes of a 10x1 fill.
        run_fill(19'd0, 10, 1, 8'h77, 0, 0, 0, 5, nwr, dcyc, la);
        chk("abort_nwr", 32'(nwr), 32'd5);
        chk("abort_no_done", 32'(dcyc), 32'hFFFF_FFFF);

        // Reset in the middle of a wrapping fill.
        fill_base = 19'h7FFFE; fill_w = 10'd4; fill_h = 10'd1; fill_color = 8'hC3;
        fill_start = 1'b1;
        drive_proc(1'b0);
        step();
        fill_start = 1'b0;
        #1;
        chk("rstmid_a0", 32'(bus.mem_addr), 32'h7FFFE);
        step();
        chk("rstmid_a1", 32'(bus.mem_addr), 32'h7FFFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rstmid_busy", 32'(fill_busy), 32'd0);
            chk("rstmid_grant", 32'(fill_grant), 32'd0);
            chk("rstmid_wren", 32'(bus.mem_wren), 32'd0);
            step();
        end
        bus.proc_req = 1'b1; bus.proc_wren = 1'b1;
        #1;
        chk("rstmid_proc_wren", 32'(bus.mem_wren), 32'd1);
        chk_proc_path();
        step();
        drive_proc(1'b0);
        step();

        // Randomized fills with random processor traffic and occasional aborts.
        for (int t = 0; t < 25; t++) begin
            w    = $urandom_range(6);
            h    = $urandom_range(4);
            base = ($urandom_range(3) == 0) ? 19'(19'h7FFF0 + 19'($urandom_range(15)))
                                            : 19'($urandom);
            ab   = ($urandom_range(4) == 0) ? $urandom_range(5) : -1;
            run_fill(base, w, h, 8'($urandom), 0, 0, 30, ab, nwr, dcyc, la);
            if (ab < 0 || ab >= w * h) chk("rand_nwr", 32'(nwr), 32'(w * h));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
